// File: rtl/rpn_stack_calc.sv
// RPN stack calculator: edge-detected Enter/Exec/Undo requests drive a small
// operand stack with a one-cycle execute phase, NZCV flags and single-level undo.
module rpn_stack_calc #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         Enter,
   input  logic                         Exec,
   input  logic                         Undo,
   input  logic [WIDTH-1:0]             DataIn,
   input  logic [2:0]                   OpCode,
   output logic [WIDTH-1:0]             Top,
   output logic [$clog2(DEPTH+1)-1:0]   Count,
   output logic [3:0]                   Flags,
   output logic [1:0]                   Status
);

   localparam int CW = $clog2(DEPTH+1);

   typedef enum logic [1:0] {
      S_READY = 2'b00,
      S_EXEC  = 2'b01,
      S_ERR   = 2'b10
   } state_t;

   state_t r_state, w_next;

   logic r_enter_d, r_exec_d, r_undo_d;
   logic w_undo_p, w_exec_raw, w_exec_p, w_enter_p;

   logic [WIDTH-1:0] r_stk      [DEPTH];
   logic [WIDTH-1:0] r_snap_stk [DEPTH];
   logic [CW-1:0]    r_cnt, r_snap_cnt;
   logic [3:0]       r_flags, r_snap_flags;
   logic             r_undo_v;
   logic [WIDTH-1:0] r_a, r_b;
   logic [2:0]       r_op;

   logic             w_full, w_can_exec;
   logic             w_push, w_latch, w_write, w_restore;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_diff, w_res, w_top;
   logic             w_c, w_v;

   // Request pulses, with lower priorities masked by any higher one
   assign w_undo_p   = Undo & ~r_undo_d;
   assign w_exec_raw = Exec & ~r_exec_d;
   assign w_exec_p   = w_exec_raw & ~w_undo_p;
   assign w_enter_p  = Enter & ~r_enter_d & ~w_exec_raw & ~w_undo_p;

   assign w_full     = (r_cnt == CW'(DEPTH));
   assign w_can_exec = (r_cnt >= CW'(2)) && (OpCode < 3'd6);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_READY;
         r_enter_d <= 1'b0;
         r_exec_d  <= 1'b0;
         r_undo_d  <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_enter_d <= Enter;
         r_exec_d  <= Exec;
         r_undo_d  <= Undo;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_READY: begin
            if (w_undo_p)       w_next = S_READY;
            else if (w_exec_p)  w_next = w_can_exec ? S_EXEC : S_ERR;
            else if (w_enter_p) w_next = w_full ? S_ERR : S_READY;
         end
         S_EXEC:  w_next = S_READY;
         S_ERR:   if (w_undo_p) w_next = S_READY;
         default: w_next = S_READY;
      endcase
   end

   always_comb begin
      Status    = r_state;
      w_push    = (r_state == S_READY) && w_enter_p && !w_full;
      w_latch   = (r_state == S_READY) && w_exec_p && w_can_exec;
      w_write   = (r_state == S_EXEC);
      w_restore = (r_state == S_READY) && w_undo_p && r_undo_v;
   end

   // Result and flags are computed from the operands latched on entry to EXEC
   always_comb begin
      w_sum  = {1'b0, r_a} + {1'b0, r_b};
      w_diff = r_a - r_b;
      w_res  = '0;
      w_c    = 1'b0;
      w_v    = 1'b0;
      case (r_op)
         3'b000: begin
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         3'b001: begin
            w_res = w_diff;
            w_c   = (r_a < r_b);
            w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         3'b010:  w_res = r_a & r_b;
         3'b011:  w_res = r_a | r_b;
         3'b100:  w_res = r_a ^ r_b;
         3'b101:  w_res = (r_a > r_b) ? r_a : r_b;
         default: w_res = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_stk[i]      <= '0;
            r_snap_stk[i] <= '0;
         end
         r_cnt        <= '0;
         r_snap_cnt   <= '0;
         r_flags      <= '0;
         r_snap_flags <= '0;
         r_undo_v     <= 1'b0;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= '0;
      end else if (w_push) begin
         r_snap_stk   <= r_stk;
         r_snap_cnt   <= r_cnt;
         r_snap_flags <= r_flags;
         r_undo_v     <= 1'b1;
         for (int unsigned i = 0; i < DEPTH; i++)
            if (r_cnt == CW'(i)) r_stk[i] <= DataIn;
         r_cnt <= r_cnt + CW'(1);
      end else if (w_latch) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++)
            if (r_cnt == CW'(i + 2)) begin
               r_a <= r_stk[i];
               r_b <= r_stk[i+1];
            end
         r_op <= OpCode;
      end else if (w_write) begin
         r_snap_stk   <= r_stk;
         r_snap_cnt   <= r_cnt;
         r_snap_flags <= r_flags;
         r_undo_v     <= 1'b1;
         for (int unsigned i = 0; i + 1 < DEPTH; i++)
            if (r_cnt == CW'(i + 2)) r_stk[i] <= w_res;
         r_cnt   <= r_cnt - CW'(1);
         r_flags <= {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
      end else if (w_restore) begin
         r_stk    <= r_snap_stk;
         r_cnt    <= r_snap_cnt;
         r_flags  <= r_snap_flags;
         r_undo_v <= 1'b0;
      end
   end

   always_comb begin
      w_top = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         if (r_cnt == CW'(i + 1)) w_top = r_stk[i];
   end

   assign Top   = w_top;
   assign Count = r_cnt;
   assign Flags = r_flags;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Directed bench for rpn_stack_calc (WIDTH=16, DEPTH=4) with hand-computed expectations.
module tb_rpn_stack_calc;

   logic        clk = 1'b0;
   logic        reset;
   logic        Enter, Exec, Undo;
   logic [15:0] DataIn;
   logic [2:0]  OpCode;
   logic [15:0] Top;
   logic [2:0]  Count;
   logic [3:0]  Flags;
   logic [1:0]  Status;

   int checks = 0;
   int errors = 0;

   rpn_stack_calc #(.WIDTH(16), .DEPTH(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .Enter  (Enter),
      .Exec   (Exec),
      .Undo   (Undo),
      .DataIn (DataIn),
      .OpCode (OpCode),
      .Top    (Top),
      .Count  (Count),
      .Flags  (Flags),
      .Status (Status)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic [15:0] t, input logic [2:0] c,
                            input logic [3:0] f, input logic [1:0] s);
      chk({tag, ".Top"},    32'(Top),    32'(t));
      chk({tag, ".Count"},  32'(Count),  32'(c));
      chk({tag, ".Flags"},  32'(Flags),  32'(f));
      chk({tag, ".Status"}, 32'(Status), 32'(s));
   endtask

   task automatic push(input logic [15:0] v);
      DataIn = v; Enter = 1'b1; tick();
      Enter = 1'b0; tick();
   endtask

   task automatic exec_op(input logic [2:0] op);
      OpCode = op; Exec = 1'b1; tick();
      Exec = 1'b0; tick();
   endtask

   task automatic undo();
      Undo = 1'b1; tick();
      Undo = 1'b0; tick();
   endtask

   task automatic do_reset();
      reset = 1'b1; tick();
      reset = 1'b0; tick();
   endtask

   initial begin
      reset = 1'b1; Enter = 1'b0; Exec = 1'b0; Undo = 1'b0;
      DataIn = '0; OpCode = '0;
      tick(); tick();
      chk_state("reset", 16'h0000, 3'd0, 4'b0000, 2'b00);
      reset = 1'b0; tick();

      // Subtract, including the intermediate EXEC cycle
      push(16'h0005);
      chk("push1.Top", 32'(Top), 32'h0005);
      push(16'h0003);
      chk("push2.Count", 32'(Count), 32'd2);
      OpCode = 3'b001; Exec = 1'b1; tick();
      chk("sub.mid.Status", 32'(Status), 32'h1);
      chk("sub.mid.Top", 32'(Top), 32'h0003);
      Exec = 1'b0; tick();
      chk_state("sub", 16'h0002, 3'd1, 4'b0000, 2'b00);

      // Borrow, carry, max and logic ops
      do_reset();
      push(16'h0003); push(16'h0005); exec_op(3'b001);
      chk_state("sub.borrow", 16'hFFFE, 3'd1, 4'b1010, 2'b00);
      push(16'hFFFF); push(16'h0001); exec_op(3'b000);
      chk_state("add.carry", 16'h0000, 3'd2, 4'b0110, 2'b00);
      exec_op(3'b101);
      chk_state("max", 16'hFFFE, 3'd1, 4'b1000, 2'b00);
      push(16'h00F0); exec_op(3'b010);
      chk_state("and", 16'h00F0, 3'd1, 4'b0000, 2'b00);
      push(16'h0F0F); exec_op(3'b100);
      chk_state("xor", 16'h0FFF, 3'd1, 4'b0000, 2'b00);
      push(16'hF000); exec_op(3'b011);
      chk_state("or", 16'hFFFF, 3'd1, 4'b1000, 2'b00);

      // Signed overflow then undo
      do_reset();
      push(16'h7FFF); push(16'h0001); exec_op(3'b000);
      chk_state("add.ovf", 16'h8000, 3'd1, 4'b1001, 2'b00);
      undo();
      chk_state("undo1", 16'h0001, 3'd2, 4'b0000, 2'b00);
      undo();
      chk_state("undo2", 16'h0001, 3'd2, 4'b0000, 2'b00);

      // Overflow into ERR, ignored requests, clear
      do_reset();
      push(16'h0001); push(16'h0002); push(16'h0003); push(16'h0004);
      chk_state("full", 16'h0004, 3'd4, 4'b0000, 2'b00);
      push(16'h0005);
      chk_state("overflow", 16'h0004, 3'd4, 4'b0000, 2'b10);
      push(16'h0006);
      exec_op(3'b000);
      chk_state("err.ignore", 16'h0004, 3'd4, 4'b0000, 2'b10);
      undo();
      chk_state("err.clear", 16'h0004, 3'd4, 4'b0000, 2'b00);
      undo();
      chk_state("err.undo_kept", 16'h0003, 3'd3, 4'b0000, 2'b00);

      // Underflow and invalid opcode
      do_reset();
      push(16'h0009); exec_op(3'b000);
      chk_state("underflow", 16'h0009, 3'd1, 4'b0000, 2'b10);
      undo();
      chk("underflow.clear", 32'(Status), 32'h0);
      push(16'h0004); exec_op(3'b111);
      chk_state("badop", 16'h0004, 3'd2, 4'b0000, 2'b10);
      undo();

      // Priority and held level
      do_reset();
      DataIn = 16'h00AA; Enter = 1'b1; Undo = 1'b1; tick();
      Enter = 1'b0; Undo = 1'b0; tick();
      chk_state("enter_undo", 16'h0000, 3'd0, 4'b0000, 2'b00);
      DataIn = 16'h00BB; Enter = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      Enter = 1'b0; tick();
      chk_state("held", 16'h00BB, 3'd1, 4'b0000, 2'b00);
      push(16'h00CC);
      DataIn = 16'h0011; OpCode = 3'b000; Exec = 1'b1; Enter = 1'b1; tick();
      Exec = 1'b0; Enter = 1'b0; tick();
      chk_state("exec_over_enter", 16'h0187, 3'd1, 4'b0000, 2'b00);

      // Reset during EXEC
      do_reset();
      push(16'h0002); push(16'h0003);
      OpCode = 3'b000; Exec = 1'b1; tick();
      chk("rst_exec.mid", 32'(Status), 32'h1);
      reset = 1'b1; #1;
      chk_state("rst_exec.async", 16'h0000, 3'd0, 4'b0000, 2'b00);
      Exec = 1'b0; tick();
      reset = 1'b0; tick(); tick();
      chk_state("rst_exec.after", 16'h0000, 3'd0, 4'b0000, 2'b00);

      // Input held high through reset release yields one pulse
      reset = 1'b1; DataIn = 16'h0055; Enter = 1'b1; tick();
      reset = 1'b0; tick();
      Enter = 1'b0; tick();
      chk_state("held_rst", 16'h0055, 3'd1, 4'b0000, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rpn_stack_calc.md
RPN_STACK_CALC -- requirements
Module: rpn_stack_calc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (≥4).
REQ-002 SHALL have parameter DEPTH, default 4, stack entries (≥2).
REQ-003 SHALL have port clk  input  1  single clock, all state updated on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Enter  input  1  level; rising edge requests push of DataIn.
REQ-006 SHALL have port Exec  input  1  level; rising edge requests execution of OpCode.
REQ-007 SHALL have port Undo  input  1  level; rising edge requests undo or error clear.
REQ-008 SHALL have port DataIn  input  WIDTH  operand to push.
REQ-009 SHALL have port OpCode  input  3  operation select, sampled when Exec edge is detected.
REQ-010 SHALL have port Top  output  WIDTH  current top-of-stack; 0 when stack empty.
REQ-011 SHALL have port Count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-012 SHALL have port Flags  output  4  {N,Z,C,V} of last completed execution.
REQ-013 SHALL have port Status  output  2  00 READY, 01 EXEC, 10 ERR.

Function
REQ-014 SHALL detect each request as input high now, registered copy low (one pulse per rising level), registered copies cleared by reset.
REQ-015 SHALL give simultaneous pulses priority Undo > Exec > Enter; lower-priority pulses in the same cycle are discarded.
REQ-016 SHALL, in READY on Enter pulse with Count<DEPTH, push DataIn: Top=DataIn, Count+1, visible after the same edge.
REQ-017 SHALL, in READY on Enter pulse with Count==DEPTH, leave stack unchanged and go to ERR (overflow).
REQ-018 SHALL, in READY on Exec pulse with Count≥2 and valid OpCode, latch A=entry below top, B=top, OpCode and go to EXEC.
REQ-019 SHALL, in READY on Exec pulse with Count<2 or OpCode 110/111, leave stack unchanged and go to ERR.
REQ-020 SHALL, in EXEC (exactly one cycle), pop A and B, push result, update Flags, return to READY; Exec-to-result latency = 2 edges, Count decreases by 1.
REQ-021 SHALL ignore Enter and Exec pulses while in EXEC or ERR.
REQ-022 SHALL implement OpCode: 000 A+B, 001 A−B, 010 A&B, 011 A|B, 100 A^B, 101 unsigned max(A,B); results truncated to WIDTH bits.
REQ-023 SHALL set N=result MSB, Z=(result==0); C=carry-out for ADD, C=borrow (A<B unsigned) for SUB; V=signed overflow for ADD/SUB; C=V=0 for other ops.
REQ-024 SHALL, before every successful push or EXEC write, snapshot entire stack, Count and Flags, and set undo-valid.
REQ-025 SHALL, in READY on Undo pulse with undo-valid set, restore the snapshot and clear undo-valid; with undo-valid clear, do nothing.
REQ-026 SHALL, in ERR on Undo pulse, return to READY with stack, Count, Flags and undo-valid unchanged.
REQ-027 SHALL ignore Undo pulses in EXEC.
REQ-028 SHALL keep entries above Count unobservable; Top reflects entry Count−1.

Reset
REQ-029 SHALL, on reset assertion, immediately set Status=READY, Count=0, Top=0, Flags=0000, undo-valid=0, all stack and snapshot entries 0, edge-detector registers 0.
REQ-030 SHALL abort any EXEC in progress on reset with no result written.
REQ-031 SHALL not produce a pulse on the first edge after reset release for an input held low through reset; an input held high through reset release SHALL produce a pulse.

Verification (WIDTH=16, DEPTH=4)
REQ-032 SHALL pass: push 0x0005, push 0x0003, Exec 001 -> two edges after Exec: Top=0x0002, Count=1, Flags=0000.
REQ-033 SHALL pass: push 0x7FFF, push 0x0001, Exec 000 -> Top=0x8000, Flags N=1 Z=0 C=0 V=1; then Undo -> Top=0x0001, Count=2, Flags=0000; second Undo -> no change.
REQ-034 SHALL pass: push four values, fifth Enter -> Status=10, Count=4, Top unchanged; Enter ignored; Undo -> Status=00, stack intact.
REQ-035 SHALL pass: Count=1, Exec 000 -> Status=10; Exec with OpCode 111 at Count=2 -> Status=10, stack unchanged.
REQ-036 SHALL pass: Enter and Undo rising same cycle with undo-valid=0 -> nothing happens; Enter held high 10 cycles -> exactly one push.
REQ-037 SHALL pass: reset asserted during EXEC -> all outputs zero/READY immediately, no result written after release.
